// File: rtl/wb_axisout_pkg.sv
// ============================================================================
//  Module      : wb_axisout_pkg
//  Description : Shared constants for the Wishbone-to-AXIS output bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_axisout_pkg;

    // Wishbone user window tag and register offsets
    localparam logic [7:0] WIN_TAG  = 8'h30;
    localparam logic [7:0] OFS_POP  = 8'h84;
    localparam logic [7:0] OFS_STAT = 8'h8C;
    localparam logic [7:0] OFS_CLR  = 8'h90;

    // Bridge FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_POP  = 2'd1;
    localparam logic [1:0] ST_STAT = 2'd2;
    localparam logic [1:0] ST_CLR  = 2'd3;

    // Status word layout
    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_LAST_BIT  = 2;
    localparam int STAT_CNT_LSB   = 8;
    localparam int STAT_CNT_W     = 5;

    function automatic logic [31:0] status_word(
        input logic                  empty,
        input logic                  full,
        input logic                  last_seen,
        input logic [STAT_CNT_W-1:0] count
    );
        logic [31:0] word;
        word                               = '0;
        word[STAT_EMPTY_BIT]               = empty;
        word[STAT_FULL_BIT]                = full;
        word[STAT_LAST_BIT]                = last_seen;
        word[STAT_CNT_LSB +: STAT_CNT_W]   = count;
        return word;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_axisout_fifo.sv
// ============================================================================
//  Module      : axis_sync_fifo
//  Description : Single-clock circular FIFO with flush and head-of-queue output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [PTR_W-1:0] r_wptr_q, w_wptr_d;
    logic [PTR_W-1:0] r_rptr_q, w_rptr_d;
    logic [CNT_W-1:0] r_count_q, w_count_d;
    logic             w_do_push, w_do_pop;

    assign o_full    = (r_count_q == CNT_W'(DEPTH));
    assign o_empty   = (r_count_q == '0);
    assign o_count   = r_count_q;
    assign o_head    = r_mem_q[r_rptr_q];
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Power-of-two depth lets the pointers wrap by plain overflow
    always_comb begin
        w_wptr_d  = r_wptr_q;
        w_rptr_d  = r_rptr_q;
        w_count_d = r_count_q;
        if (i_flush) begin
            w_wptr_d  = '0;
            w_rptr_d  = '0;
            w_count_d = '0;
        end else begin
            if (w_do_push) w_wptr_d = r_wptr_q + PTR_W'(1);
            if (w_do_pop)  w_rptr_d = r_rptr_q + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   w_count_d = r_count_q + CNT_W'(1);
                2'b01:   w_count_d = r_count_q - CNT_W'(1);
                default: w_count_d = r_count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr_q  <= '0;
            r_rptr_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_wptr_q  <= w_wptr_d;
            r_rptr_q  <= w_rptr_d;
            r_count_q <= w_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem_q[r_wptr_q] <= i_wdata;
    end

endmodule

`default_nettype wire

// File: rtl/wb_axisout.sv
// ============================================================================
//  Module      : wb_axisout
//  Description : Wishbone read-out bridge for the FIR result AXI-Stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_axisout
    import wb_axisout_pkg::*;
#(
    parameter int pADDR_WIDTH  = 12,
    parameter int pDATA_WIDTH  = 32,
    parameter int OutFifoDepth = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_dat_i,
    input  logic [31:0]            wbs_adr_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    input  logic                   sm_tvalid,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    input  logic                   sm_tlast,
    output logic                   sm_tready
);

    localparam int ENTRY_W = pDATA_WIDTH + 1;
    localparam int CNT_W   = $clog2(OutFifoDepth) + 1;

    logic [1:0]         r_state_q, w_state_d;
    logic               r_last_seen_q, w_last_seen_d;
    logic               w_hit;
    logic [7:0]         w_ofs;
    logic               w_push, w_pop, w_flush;
    logic [ENTRY_W-1:0] w_head;
    logic               w_full, w_empty;
    logic [CNT_W-1:0]   w_count;
    logic               w_unused_ok;

    assign w_hit       = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:24] == WIN_TAG);
    assign w_ofs       = wbs_adr_i[7:0];
    assign w_push      = sm_tvalid & sm_tready;
    assign w_unused_ok = ^{wbs_sel_i, wbs_dat_i, wbs_adr_i[23:8], 32'(pADDR_WIDTH)};

    axis_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (OutFifoDepth)
    ) u_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_wdata ({sm_tlast, sm_tdata}),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state_q     <= ST_IDLE;
            r_last_seen_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_last_seen_q <= w_last_seen_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_IDLE: begin
                if (w_hit && !wbs_we_i && w_ofs == OFS_POP)       w_state_d = ST_POP;
                else if (w_hit && !wbs_we_i && w_ofs == OFS_STAT) w_state_d = ST_STAT;
                else if (w_hit && wbs_we_i && w_ofs == OFS_CLR)   w_state_d = ST_CLR;
            end
            // A dropped cycle abandons the read; otherwise wait for data
            ST_POP: begin
                if (!wbs_cyc_i || !w_empty) w_state_d = ST_IDLE;
            end
            ST_STAT: w_state_d = ST_IDLE;
            ST_CLR:  w_state_d = ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wbs_ack_o     = 1'b0;
        wbs_dat_o     = '0;
        w_pop         = 1'b0;
        w_flush       = 1'b0;
        w_last_seen_d = r_last_seen_q;
        case (r_state_q)
            ST_POP: begin
                if (wbs_cyc_i && !w_empty) begin
                    wbs_ack_o = 1'b1;
                    wbs_dat_o = 32'(w_head[pDATA_WIDTH-1:0]);
                    w_pop     = 1'b1;
                    if (w_head[pDATA_WIDTH]) w_last_seen_d = 1'b1;
                end
            end
            ST_STAT: begin
                wbs_ack_o = 1'b1;
                wbs_dat_o = status_word(w_empty, w_full, r_last_seen_q,
                                        STAT_CNT_W'(w_count));
            end
            ST_CLR: begin
                wbs_ack_o     = 1'b1;
                w_flush       = 1'b1;
                w_last_seen_d = 1'b0;
            end
            default: ;
        endcase
        // Depends on the registered count only, so a pop never frees a slot same-cycle
        sm_tready = ~wb_rst_i & (w_count < CNT_W'(OutFifoDepth)) & (r_state_q != ST_CLR);
    end

endmodule

`default_nettype wire

// File: tb/tb_wb_axisout.sv
// Randomized scoreboard bench for wb_axisout against a queue-based reference model.
`default_nettype none

module tb_wb_axisout;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [31:0] wbs_dat_i = '0, wbs_adr_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        sm_tvalid = 1'b0, sm_tlast = 1'b0;
    logic [31:0] sm_tdata = '0;
    logic        sm_tready;

    wb_axisout #(.pADDR_WIDTH(12), .pDATA_WIDTH(32), .OutFifoDepth(DEPTH)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (wb_rst_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .sm_tvalid (sm_tvalid),
        .sm_tdata  (sm_tdata),
        .sm_tlast  (sm_tlast),
        .sm_tready (sm_tready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        chk;
        logic [31:0] dat;
    } sb_t;

    sb_t         sb[$];
    logic [32:0] model[$];
    logic        model_last = 1'b0;
    int          checks = 0;
    int          errors = 0;
    sb_t         mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Status word derived from the model contents
    function automatic logic [31:0] model_status();
        int n = model.size();
        return (32'(n) << 8) | (32'(model_last) << 2) |
               (32'(n == DEPTH) << 1) | 32'(n == 0);
    endfunction

    always @(negedge clk) begin
        if (!wb_rst_i) begin
            if (wbs_ack_o) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack=1 dat=%h required no ack at %0t",
                             wbs_dat_o, $time);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.chk) check("ack_data", wbs_dat_o, mon_e.dat);
                end
            end else begin
                check("dat_idle", wbs_dat_o, 32'h0);
            end
        end
    end

    // All tasks start and end at 1 time unit after a rising edge
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input bit exp_ack,
                           input bit chk, input logic [31:0] exp_dat);
        int waits;
        if (exp_ack) sb.push_back('{chk: chk, dat: exp_dat});
        wbs_adr_i = adr;
        wbs_we_i  = we;
        wbs_dat_i = $urandom;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        if (exp_ack) begin
            waits = 0;
            @(negedge clk);
            while (!wbs_ack_o && waits < 20) begin
                waits++;
                @(negedge clk);
            end
            if (!wbs_ack_o) begin
                checks++;
                errors++;
                $display("FAIL ack_timeout: got no ack required ack for adr %h", adr);
                void'(sb.pop_back());
            end else begin
                check("ack_latency", 32'(waits), 32'd1);
                if (we) check("tready_in_clr", {31'd0, sm_tready}, 32'd0);
            end
            @(posedge clk); #1;
            wbs_stb_i = 1'b0;
            wbs_cyc_i = 1'b0;
            if (we) begin
                @(negedge clk);
                check("tready_after_clr", {31'd0, sm_tready}, 32'd1);
                @(posedge clk); #1;
            end
        end else begin
            repeat (3) @(posedge clk);
            #1;
            wbs_stb_i = 1'b0;
            wbs_cyc_i = 1'b0;
        end
    endtask

    task automatic push_beat(input logic [31:0] d, input logic l);
        bit acc = (model.size() < DEPTH);
        sm_tvalid = 1'b1;
        sm_tdata  = d;
        sm_tlast  = l;
        @(negedge clk);
        check("tready", {31'd0, sm_tready}, {31'd0, acc});
        @(posedge clk); #1;
        sm_tvalid = 1'b0;
        if (acc) model.push_back({l, d});
    endtask

    task automatic pop_expect();
        logic [32:0] e = model.pop_front();
        if (e[32]) model_last = 1'b1;
        wb_xfer(1'b0, 32'h3000_0084, 1'b1, 1'b1, e[31:0]);
    endtask

    task automatic stat_read();
        wb_xfer(1'b0, 32'h3000_008C, 1'b1, 1'b1, model_status());
    endtask

    task automatic clr_write();
        model.delete();
        model_last = 1'b0;
        wb_xfer(1'b1, 32'h3000_0090, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic bad_access(input int k);
        case (k)
            0:       wb_xfer(1'b1, 32'h3000_0080, 1'b0, 1'b0, 32'h0);
            1:       wb_xfer(1'b0, 32'h3100_0084, 1'b0, 1'b0, 32'h0);
            2:       wb_xfer(1'b1, 32'h3000_0084, 1'b0, 1'b0, 32'h0);
            3:       wb_xfer(1'b0, 32'h3000_0090, 1'b0, 1'b0, 32'h0);
            default: wb_xfer(1'b0, 32'h3000_0010, 1'b0, 1'b0, 32'h0);
        endcase
    endtask

    task automatic do_reset();
        wb_rst_i  = 1'b1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        sm_tvalid = 1'b0;
        @(negedge clk);
        check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_tready", {31'd0, sm_tready}, 32'd0);
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        model.delete();
        model_last = 1'b0;
        sb.delete();
        @(negedge clk);
        check("tready_after_rst", {31'd0, sm_tready}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk); #1;
        do_reset();
        check("status_after_reset", model_status(), 32'h0000_0001);
        stat_read();

        push_beat(32'h11, 1'b0);
        push_beat(32'h22, 1'b0);
        push_beat(32'h33, 1'b1);
        repeat (3) pop_expect();
        check("status_model_last", model_status(), 32'h0000_0005);
        stat_read();

        // Fill to full, hold a ninth beat across one pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_beat(32'hA000_0000 + 32'(i), 1'b0);
        stat_read();
        sm_tvalid = 1'b1;
        sm_tdata  = 32'h99;
        sm_tlast  = 1'b0;
        @(negedge clk);
        check("tready_full", {31'd0, sm_tready}, 32'd0);
        @(posedge clk); #1;
        pop_expect();
        @(negedge clk);
        check("tready_after_pop", {31'd0, sm_tready}, 32'd1);
        @(posedge clk); #1;
        sm_tvalid = 1'b0;
        model.push_back({1'b0, 32'h99});
        while (model.size() > 0) pop_expect();
        stat_read();

        // Stalled pop released by a late push
        wbs_adr_i = 32'h3000_0084;
        wbs_we_i  = 1'b0;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_no_ack", {31'd0, wbs_ack_o}, 32'd0);
            @(posedge clk); #1;
        end
        sb.push_back('{chk: 1'b1, dat: 32'hABCD});
        sm_tvalid = 1'b1;
        sm_tdata  = 32'hABCD;
        sm_tlast  = 1'b0;
        @(negedge clk);
        check("no_bypass", {31'd0, wbs_ack_o}, 32'd0);
        @(posedge clk); #1;
        sm_tvalid = 1'b0;
        @(negedge clk);
        check("ack_after_push", {31'd0, wbs_ack_o}, 32'd1);
        @(posedge clk); #1;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        stat_read();

        // Clear with entries pending and last_seen set
        push_beat(32'h5, 1'b1);
        pop_expect();
        for (int i = 0; i < 4; i++) push_beat($urandom, 1'(i == 3));
        stat_read();
        clr_write();
        check("status_after_clr", model_status(), 32'h0000_0001);
        stat_read();

        // Foreign offsets and windows leave FIFO untouched
        push_beat(32'h77, 1'b0);
        push_beat(32'h88, 1'b1);
        for (int k = 0; k < 5; k++) bad_access(k);
        stat_read();

        // Reset discards contents, also during a stalled pop
        do_reset();
        stat_read();
        wbs_adr_i = 32'h3000_0084;
        wbs_we_i  = 1'b0;
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("stall_no_ack2", {31'd0, wbs_ack_o}, 32'd0);
            @(posedge clk);
        end
        #3 wb_rst_i = 1'b1;
        #1;
        check("midrst_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("midrst_tready", {31'd0, sm_tready}, 32'd0);
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        @(posedge clk); #1;
        wb_rst_i = 1'b0;
        model.delete();
        model_last = 1'b0;
        sb.delete();
        stat_read();

        // Randomized mix
        for (int n = 0; n < 200; n++) begin
            int op = $urandom_range(0, 9);
            if (op <= 3)                           push_beat($urandom, ($urandom_range(0, 3) == 0));
            else if (op <= 6 && model.size() > 0)  pop_expect();
            else if (op == 8)                      bad_access($urandom_range(0, 4));
            else if (op == 9 && $urandom_range(0, 3) == 0) clr_write();
            else                                   stat_read();
        end
        while (model.size() > 0) pop_expect();
        stat_read();

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wb_axisout.md
Name: wb_axisout

Overview:
- Wishbone-to-AXI-Stream output bridge; the return path of the FIR offload.
- Accepts the FIR result stream on an AXIS slave port (sm_*) and buffers it in a small FIFO.
- The Caravel management core drains results, and reads status, through Wishbone reads in the 0x30xx_xxxx user window.
- Shares that window with the input bridge. It responds only to its own offsets and leaves 0x10/0x80/0x88 unacknowledged.

Parameters:
- pADDR_WIDTH, 12, address width kept for interface uniformity (unused internally).
- pDATA_WIDTH, 32, AXIS data width.
- OutFifoDepth, 8, FIFO entries; power of two, 2..16.

Ports:
- wb_clk_i  input  1  single clock for Wishbone and AXIS.
- wb_rst_i  input  1  reset, asynchronous, active-high.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_we_i  input  1  Wishbone write enable.
- wbs_sel_i  input  4  byte selects (ignored; full-word access only).
- wbs_dat_i  input  32  write data.
- wbs_adr_i  input  32  address.
- wbs_ack_o  output  1  acknowledge.
- wbs_dat_o  output  32  read data.
- sm_tvalid  input  1  AXIS valid from FIR.
- sm_tdata  input  pDATA_WIDTH  AXIS data.
- sm_tlast  input  1  AXIS last beat of the result frame.
- sm_tready  output  1  AXIS ready to FIR.

Behaviour:
- Reset values: wbs_ack_o=0, wbs_dat_o=0, sm_tready=0 while wb_rst_i is high. FIFO count and pointers 0, sticky last flag 0, state IDLE.
- Decode: hit = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:24]==8'h30). Offset = wbs_adr_i[7:0].
  - 0x84 read: POP.
  - 0x8C read: STATUS.
  - 0x90 write: CLEAR.
  - Any other offset or direction: no action, no ack.
- FSM states:
  - IDLE: hit+read 0x84 -> POP; hit+read 0x8C -> STAT; hit+write 0x90 -> CLR; otherwise stay.
  - POP:
    - If wbs_cyc_i drops: -> IDLE with no pop (abort).
    - Else if count!=0: wbs_ack_o=1 for exactly this cycle; wbs_dat_o = head data; head popped at the clock edge; -> IDLE.
    - Else: stay in POP (stall) with ack=0.
  - STAT: ack=1 for one cycle; -> IDLE. wbs_dat_o fields:
    - [0] empty
    - [1] full
    - [2] last_seen
    - [12:8] count
    - all other bits 0
  - CLR: ack=1 for one cycle. Pointers, count and last_seen are zeroed at the edge; -> IDLE.
- wbs_dat_o is 0 in every cycle where wbs_ack_o=0. Ack is combinational from state and count; data comes straight from the FIFO head (no extra latency).
- Master is required to drop stb in the cycle after ack. The IDLE return enforces a minimum of 2 cycles per transaction.
- FIFO entry is {tlast, tdata} (pDATA_WIDTH+1 bits), circular with wrapping read and write pointers. count has width clog2(depth)+1.
- sm_tready = ~wb_rst_i & (count < OutFifoDepth) & (state != CLR).
  - Depends on count only, never on a same-cycle pop: when full, a pop does not raise tready until the next cycle.
  - A beat is pushed when sm_tvalid & sm_tready.
- Simultaneous push and pop: count unchanged; both pointers advance.
- No bypass: a beat pushed while POP is stalling on empty is acked the following cycle (write-to-ack latency 1 cycle).
- last_seen is set when a popped entry carries tlast=1. It is cleared only by CLR or reset. Later pops with tlast=0 do not clear it.
- Reset asserted mid-transaction: FSM returns to IDLE, FIFO contents are discarded, ack deasserts immediately.

Decomposition:
- Shared package holds:
  - offset constants OFS_POP=8'h84, OFS_STAT=8'h8C, OFS_CLR=8'h90, and the 0x30 window tag;
  - state encodings (IDLE, POP, STAT, CLR; 2 bits);
  - the status bit positions.
- One sub-module: axis_sync_fifo. Parameterised width and depth, with push/pop/flush inputs and full/empty/count/head outputs. The bridge FSM instantiates it.

Test Plan:
- Reset, then read 0x3000_008C -> ack after 1 cycle; dat=0x0000_0001 (empty=1, count=0); sm_tready=1.
- Push 3 beats 0x11,0x22,0x33 (tlast on 0x33), then 3 reads of 0x3000_0084 -> returns 0x11, 0x22, 0x33 in order. Status read afterwards = 0x0000_0005 (empty, last_seen).
- Push 8 beats with no reads -> sm_tready=0 after the 8th; status = 0x0000_0802. A 9th beat held valid is not taken. One pop, then tready returns to 1 the cycle after the ack, and the 9th beat is accepted.
- Read 0x84 while empty -> no ack for 5 cycles. Push 0xABCD on cycle 5 -> ack on cycle 6 with dat=0xABCD.
- Fill 4 beats, write 0x3000_0090 -> ack; status reads 0x0000_0001; last_seen=0; sm_tready low only during the CLR cycle.
- Access 0x3000_0080 write or 0x3100_0084 read -> no ack, no FIFO change. Assert reset during a stalled POP -> ack=0, count=0, state IDLE.
